pipeline_valid_delay: RTL and testbench
=======================================

Name: pipeline_valid_delay

Overview:
- Parametrised successor to the plain N-cycle shift-register delay.
- Delays a WIDTH-bit payload by CYCLES stages and adds a valid bit per stage, flush, synchronous reset, an occupancy count and an optional bubble-collapsing mode with an input ready handshake.
- Used between Otter pipeline stages and for delay-matching side-band data (CSR, trap info) that must track instruction validity under stall/flush.

Parameters:
- CYCLES, 1, number of register stages; 0 = combinational passthrough.
- WIDTH, 32, payload width in bits.
- COLLAPSE, 0, 0 = lock-step shift on EN only; 1 = bubbles squeezed out while the output is stalled.
- RESET_VAL, 0 (WIDTH bits), payload value loaded into every stage on reset.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- EN  input  1  downstream advance/accept; in COLLAPSE=1 it is the output-side ready.
- FLUSH  input  1  synchronous clear of all valid bits.
- in_valid  input  1  payload at input is valid.
- in  input  WIDTH  input payload.
- in_ready  output  1  input is captured at this edge if in_valid=1.
- out_valid  output  1  valid bit of stage 0.
- out  output  WIDTH  payload of stage 0.
- count  output  $clog2(CYCLES+1)  number of valid stages (combinational popcount of the valid bits).

Behaviour:
- Stages are indexed CYCLES-1 (input side) down to 0 (output side). out/out_valid come from stage 0 directly, with no output logic.
- Reset (RST=1 at an edge): all valid bits are 0 and all payloads equal RESET_VAL. After reset: out_valid=0, out=RESET_VAL, count=0.
  - RST overrides FLUSH, EN and in_valid.
  - Reset mid-operation discards all in-flight entries.
- FLUSH=1 (RST=0):
  - All valid bits are 0 after the edge; payload registers may take any value.
  - in_ready=0 during FLUSH, so the cycle's input is dropped.
  - FLUSH takes priority over EN.
- COLLAPSE=0 (lock-step):
  - in_ready = EN & ~FLUSH.
  - EN=1: every stage i loads stage i+1 (valid and payload); stage CYCLES-1 loads {in_valid, in}.
  - EN=0: all stages hold.
  - Latency: exactly CYCLES EN-asserted edges from capture to out.
  - Invalid entries (bubbles) are shifted like valid ones.
- COLLAPSE=1 (bubble-collapsing):
  - Per-stage ready: rdy[0] = EN | ~valid[0]; rdy[i] = rdy[i-1] | ~valid[i]. All terms use pre-edge state.
  - If rdy[i]=1, stage i loads stage i+1 (or the input for i=CYCLES-1); otherwise it holds.
  - in_ready = rdy[CYCLES-1] & ~FLUSH.
  - If the input is loaded with in_valid=0, the stage becomes invalid.
  - An output entry is consumed at an edge where out_valid=1 and EN=1.
  - Minimum latency is CYCLES edges. Under stall, entries advance into empty slots until the stages are full.
  - Full (count=CYCLES) with EN=0: in_ready=0 and all stages hold.
  - Empty: in_ready=1 regardless of EN.
  - Simultaneous EN=1 and input capture while full: throughput is 1 per cycle and count is unchanged.
- CYCLES=0: out=in, out_valid=in_valid & ~FLUSH, in_ready=EN & ~FLUSH, count=0. No registers.
- count never exceeds CYCLES. It is not registered, so it updates combinationally from the valid bits.
- Data ordering is strictly FIFO in both modes. Valid entries are never duplicated or dropped, except by FLUSH or RST.

Test Plan:
- Reset: CYCLES=3, hold RST for 2 edges with in_valid=1, in=0xAAAA5555 -> out_valid=0, out=RESET_VAL, count=0; after release, first capture appears at out after 3 EN edges.
- Lock-step latency: COLLAPSE=0, CYCLES=3, EN=1, values 1,2,3,4 valid on consecutive cycles -> out=1 at the 3rd edge after capture, then 2,3,4 on successive edges; count reaches 3.
- Stall: COLLAPSE=0, CYCLES=3 with 2 valid entries and a bubble, EN=0 for 4 cycles -> all outputs frozen, in_ready=0, count constant at 2.
- Bubble collapse: COLLAPSE=1, CYCLES=4, EN=0, inject 0x10 then idle 2 cycles then 0x20 -> 0x10 at stage 0 after 4 edges; 0x20 settles in stage 1; count=2; in_ready=1 until 4 valid entries, then 0 at count=4.
- Flush: COLLAPSE=1, full (count=4), assert FLUSH with EN=0 and in_valid=1 -> next cycle count=0, out_valid=0, input not captured; the next valid input reaches out after 4 edges.
- Passthrough: CYCLES=0, in=0x1234, in_valid=1, EN=1 -> same-cycle out=0x1234, out_valid=1, in_ready=1; FLUSH=1 -> out_valid=0, in_ready=0.

Source files
------------

// File: rtl/pipeline_valid_delay_if.sv
// pipeline_valid_delay_if
//   Groups the stream and control signals of pipeline_valid_delay.
//   slave  : the delay line (consumes EN/FLUSH/in_valid/in, drives the rest)
//   master : the environment driving it
//   Signals:
//     EN        downstream advance / output-side ready
//     FLUSH     synchronous clear of all valid bits
//     in_valid  input payload valid
//     in        input payload (WIDTH bits)
//     in_ready  input captured at this edge if in_valid=1
//     out_valid valid bit of stage 0
//     out       payload of stage 0
//     count     number of valid stages
interface pipeline_valid_delay_if #(
  parameter int WIDTH  = 32,
  parameter int CYCLES = 1
);
  localparam int CNT_W = (CYCLES > 0) ? $clog2(CYCLES + 1) : 1;

  logic             EN;
  logic             FLUSH;
  logic             in_valid;
  logic [WIDTH-1:0] in;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out;
  logic [CNT_W-1:0] count;

  modport slave  (input  EN, FLUSH, in_valid, in,
                  output in_ready, out_valid, out, count);
  modport master (output EN, FLUSH, in_valid, in,
                  input  in_ready, out_valid, out, count);
endinterface

// File: rtl/pipeline_valid_delay.sv
// pipeline_valid_delay
//   Delays a WIDTH-bit payload by CYCLES register stages, carrying a valid
//   bit per stage. Supports flush, synchronous reset, an occupancy count and
//   an optional bubble-collapsing mode in which stalled entries advance into
//   empty slots.
//   Ports:
//     CLK  clock, rising edge
//     RST  synchronous active-high reset (overrides everything)
//     bus  pipeline_valid_delay_if.slave (EN, FLUSH, in_valid, in,
//          in_ready, out_valid, out, count)
//   Stage CYCLES-1 is the input side, stage 0 drives the outputs directly.
module pipeline_valid_delay #(
  parameter int               CYCLES    = 1,
  parameter int               WIDTH     = 32,
  parameter bit               COLLAPSE  = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic                   CLK,
  input logic                   RST,
  pipeline_valid_delay_if.slave bus
);

  localparam int CNT_W = (CYCLES > 0) ? $clog2(CYCLES + 1) : 1;

  generate
    if (CYCLES == 0) begin : g_pass
      // No state: clock and reset are deliberately unused here.
      logic unused_clk_rst;
      assign unused_clk_rst = CLK ^ RST;

      assign bus.out       = bus.in;
      assign bus.out_valid = bus.in_valid & ~bus.FLUSH;
      assign bus.in_ready  = bus.EN & ~bus.FLUSH;
      assign bus.count     = '0;
    end else begin : g_pipe
      logic [CYCLES-1:0] vld_q;
      logic [CYCLES-1:0] vld_d;
      logic [CYCLES-1:0] rdy;
      logic [WIDTH-1:0]  dat_q [CYCLES];
      logic [WIDTH-1:0]  dat_d [CYCLES];

      function automatic logic [CNT_W-1:0] popcount(input logic [CYCLES-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < CYCLES; i++) begin
          n = n + CNT_W'(v[i]);
        end
        return n;
      endfunction

      // Ready chain from the output side upward. Lock-step: every stage moves
      // only on EN. Collapsing: a stage may also move when it or any stage
      // below it is empty, which squeezes bubbles out under stall.
      always_comb begin : ready_chain
        logic acc;
        acc = bus.EN;
        rdy = '0;
        for (int i = 0; i < CYCLES; i++) begin
          if (COLLAPSE) acc = acc | ~vld_q[i];
          rdy[i] = acc;
        end
      end

      always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        for (int i = 0; i < CYCLES - 1; i++) begin
          if (rdy[i]) begin
            vld_d[i] = vld_q[i+1];
            dat_d[i] = dat_q[i+1];
          end
        end
        if (rdy[CYCLES-1]) begin
          vld_d[CYCLES-1] = bus.in_valid;
          dat_d[CYCLES-1] = bus.in;
        end
        // Payloads still move on flush; only the valid bits matter afterwards.
        if (bus.FLUSH) vld_d = '0;
      end

      // Stage registers
      always_ff @(posedge CLK) begin
        if (RST) begin
          vld_q <= '0;
          for (int i = 0; i < CYCLES; i++) dat_q[i] <= RESET_VAL;
        end else begin
          vld_q <= vld_d;
          for (int i = 0; i < CYCLES; i++) dat_q[i] <= dat_d[i];
        end
      end

      assign bus.in_ready  = rdy[CYCLES-1] & ~bus.FLUSH;
      assign bus.out_valid = vld_q[0];
      assign bus.out       = dat_q[0];
      assign bus.count     = popcount(vld_q);
    end
  endgenerate

endmodule

// File: tb/tb_pipeline_valid_delay.sv
module tb_pipeline_valid_delay;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  pipeline_valid_delay_if #(.WIDTH(32), .CYCLES(3)) a3();
  pipeline_valid_delay_if #(.WIDTH(32), .CYCLES(4)) a4();
  pipeline_valid_delay_if #(.WIDTH(32), .CYCLES(0)) a0();

  pipeline_valid_delay #(.CYCLES(3), .WIDTH(32), .COLLAPSE(1'b0), .RESET_VAL(32'hDEAD_BEEF))
    u3 (.CLK(CLK), .RST(RST), .bus(a3.slave));
  pipeline_valid_delay #(.CYCLES(4), .WIDTH(32), .COLLAPSE(1'b1), .RESET_VAL(32'h0000_C0DE))
    u4 (.CLK(CLK), .RST(RST), .bus(a4.slave));
  pipeline_valid_delay #(.CYCLES(0), .WIDTH(32), .COLLAPSE(1'b0), .RESET_VAL(32'h0))
    u0 (.CLK(CLK), .RST(RST), .bus(a0.slave));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    a3.EN = 1'b1; a3.FLUSH = 1'b0; a3.in_valid = 1'b1; a3.in = 32'hAAAA_5555;
    a4.EN = 1'b0; a4.FLUSH = 1'b0; a4.in_valid = 1'b1; a4.in = 32'hAAAA_5555;
    a0.EN = 1'b0; a0.FLUSH = 1'b0; a0.in_valid = 1'b0; a0.in = 32'h0;

    // ---------------- reset held for 2 edges with valid input
    for (int k = 0; k < 2; k++) begin
      step();
      check_eq("rst3_out_valid", a3.out_valid, 0);
      check_eq("rst3_out", a3.out, 64'hDEAD_BEEF);
      check_eq("rst3_count", a3.count, 0);
      check_eq("rst4_count", a4.count, 0);
      check_eq("rst4_out", a4.out, 64'hC0DE);
    end
    RST = 1'b0;
    a4.in_valid = 1'b0;

    // ---------------- passthrough (CYCLES=0)
    a0.in = 32'h1234; a0.in_valid = 1'b1; a0.EN = 1'b1;
    #1;
    check_eq("pass_out", a0.out, 64'h1234);
    check_eq("pass_out_valid", a0.out_valid, 1);
    check_eq("pass_in_ready", a0.in_ready, 1);
    check_eq("pass_count", a0.count, 0);
    a0.FLUSH = 1'b1;
    #1;
    check_eq("pass_flush_out_valid", a0.out_valid, 0);
    check_eq("pass_flush_in_ready", a0.in_ready, 0);

    // ---------------- lock-step latency: 1,2,3,4
    a3.in_valid = 1'b1; a3.in = 32'd1; a3.EN = 1'b1;
    #1;
    check_eq("ls_in_ready", a3.in_ready, 1);
    step(); check_eq("ls_e1_vld", a3.out_valid, 0); check_eq("ls_e1_cnt", a3.count, 1);
    a3.in = 32'd2;
    step(); check_eq("ls_e2_vld", a3.out_valid, 0); check_eq("ls_e2_cnt", a3.count, 2);
    a3.in = 32'd3;
    step(); check_eq("ls_e3_out", a3.out, 1); check_eq("ls_e3_vld", a3.out_valid, 1);
    check_eq("ls_e3_cnt", a3.count, 3);
    a3.in = 32'd4;
    step(); check_eq("ls_e4_out", a3.out, 2); check_eq("ls_e4_cnt", a3.count, 3);
    a3.in_valid = 1'b0; a3.in = 32'h0;
    step(); check_eq("ls_e5_out", a3.out, 3); check_eq("ls_e5_cnt", a3.count, 2);

    // ---------------- lock-step stall: 2 valid + bubble, offered input dropped
    a3.EN = 1'b0; a3.in_valid = 1'b1; a3.in = 32'h99;
    #1;
    check_eq("stall_in_ready", a3.in_ready, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      check_eq("stall_out", a3.out, 3);
      check_eq("stall_vld", a3.out_valid, 1);
      check_eq("stall_cnt", a3.count, 2);
      check_eq("stall_in_ready", a3.in_ready, 0);
    end
    a3.EN = 1'b1; a3.in_valid = 1'b0;
    step(); check_eq("drain_out", a3.out, 4); check_eq("drain_cnt", a3.count, 1);
    step(); check_eq("drain_vld", a3.out_valid, 0); check_eq("drain_cnt0", a3.count, 0);

    // ---------------- lock-step flush
    a3.in_valid = 1'b1; a3.in = 32'h5;
    step(); check_eq("lsf_cnt1", a3.count, 1);
    a3.EN = 1'b0; a3.FLUSH = 1'b1; a3.in = 32'h6;
    #1; check_eq("lsf_in_ready", a3.in_ready, 0);
    step(); check_eq("lsf_cnt0", a3.count, 0);
    a3.FLUSH = 1'b0; a3.in_valid = 1'b0; a3.EN = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(); check_eq("lsf_after_vld", a3.out_valid, 0);
    end

    // ---------------- bubble collapse (CYCLES=4, EN=0)
    a4.EN = 1'b0; a4.in_valid = 1'b1; a4.in = 32'h10;
    #1; check_eq("col_in_ready_empty", a4.in_ready, 1);
    step(); check_eq("col_e1_cnt", a4.count, 1);
    a4.in_valid = 1'b0;
    step(); check_eq("col_e2_vld", a4.out_valid, 0);
    step(); check_eq("col_e3_vld", a4.out_valid, 0);
    a4.in_valid = 1'b1; a4.in = 32'h20;
    step(); check_eq("col_e4_out", a4.out, 64'h10); check_eq("col_e4_vld", a4.out_valid, 1);
    check_eq("col_e4_cnt", a4.count, 2);
    a4.in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(); check_eq("col_settle_out", a4.out, 64'h10); check_eq("col_settle_cnt", a4.count, 2);
    end
    check_eq("col_in_ready_2", a4.in_ready, 1);
    a4.in_valid = 1'b1; a4.in = 32'h30;
    step(); check_eq("col_cnt3", a4.count, 3); check_eq("col_in_ready_3", a4.in_ready, 1);
    a4.in = 32'h40;
    step(); check_eq("col_cnt4", a4.count, 4); check_eq("col_in_ready_full", a4.in_ready, 0);
    a4.in = 32'h50;
    step(); check_eq("col_full_hold_cnt", a4.count, 4); check_eq("col_full_hold_out", a4.out, 64'h10);

    // full with EN=1 and capture: 1 per cycle, count unchanged
    a4.EN = 1'b1;
    #1; check_eq("col_thru_in_ready", a4.in_ready, 1);
    step(); check_eq("col_thru_out1", a4.out, 64'h20); check_eq("col_thru_cnt1", a4.count, 4);
    a4.in = 32'h60;
    step(); check_eq("col_thru_out2", a4.out, 64'h30); check_eq("col_thru_cnt2", a4.count, 4);

    // ---------------- collapse flush while full
    a4.EN = 1'b0; a4.FLUSH = 1'b1; a4.in_valid = 1'b1; a4.in = 32'h70;
    #1; check_eq("colf_in_ready", a4.in_ready, 0);
    step(); check_eq("colf_cnt", a4.count, 0); check_eq("colf_vld", a4.out_valid, 0);
    a4.FLUSH = 1'b0; a4.in = 32'h80;
    step(); check_eq("colf_cap_cnt", a4.count, 1);
    a4.in_valid = 1'b0;
    step(); step();
    check_eq("colf_e3_vld", a4.out_valid, 0);
    step(); check_eq("colf_e4_out", a4.out, 64'h80); check_eq("colf_e4_vld", a4.out_valid, 1);

    // ---------------- reset mid-operation discards in-flight entries
    a3.in_valid = 1'b1; a3.in = 32'h7; a3.EN = 1'b1;
    step(); check_eq("mid_pre_cnt3", a3.count, 1);
    RST = 1'b1;
    step();
    check_eq("mid_rst4_cnt", a4.count, 0);
    check_eq("mid_rst4_vld", a4.out_valid, 0);
    check_eq("mid_rst4_out", a4.out, 64'hC0DE);
    check_eq("mid_rst3_cnt", a3.count, 0);
    check_eq("mid_rst3_out", a3.out, 64'hDEAD_BEEF);
    RST = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
